// File: rtl/best_root_selector_if.sv
// Handshake and weights-memory bundle for the best-root selector.
// Root/cost inputs come from the update stage; mem_* go to the weights memory.
interface best_root_selector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int EXTRA_BITS = 2
);
    logic [DATA_WIDTH+EXTRA_BITS-1:0] root_in;
    logic                             root_valid;
    logic                             root_ready;
    logic [DATA_WIDTH-1:0]            cost_in;
    logic                             cost_valid;
    logic                             first_iter;
    logic [DATA_WIDTH+EXTRA_BITS-1:0] mem_data;
    logic                             mem_wr_en;
    logic                             mem_update_weight;
    logic                             mem_initial_flag;
    logic [DATA_WIDTH-1:0]            best_cost;
    logic                             best_updated;
    logic                             seq_err;

    modport master (
        output root_in, root_valid, cost_in, cost_valid, first_iter,
        input  root_ready, mem_data, mem_wr_en, mem_update_weight,
        input  mem_initial_flag, best_cost, best_updated, seq_err
    );

    modport slave (
        input  root_in, root_valid, cost_in, cost_valid, first_iter,
        output root_ready, mem_data, mem_wr_en, mem_update_weight,
        output mem_initial_flag, best_cost, best_updated, seq_err
    );
endinterface

// File: rtl/best_root_selector.sv
// Buffers one iteration's roots and replays them into the weights memory
// only when the iteration cost beats the best cost seen so far.
module best_root_selector #(
    parameter int DATA_WIDTH    = 32,
    parameter int EXTRA_BITS    = 2,
    parameter int NUM_UNKOWNS   = 4,
    parameter int ADDRESS_WIDTH = 3,
    parameter logic [DATA_WIDTH+EXTRA_BITS-1:0] PAD_VALUE = '0
) (
    input logic clk,
    input logic rst,
    best_root_selector_if.slave bus
);
    localparam int W         = DATA_WIDTH + EXTRA_BITS;
    localparam int CW        = ADDRESS_WIDTH + 1;
    localparam int RAM_DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [CW-1:0] ROOT_LEN  = CW'(NUM_UNKOWNS);
    localparam logic [CW-1:0] FULL_LEN  = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] LAST_ROOT = CW'(NUM_UNKOWNS - 1);
    localparam logic [DATA_WIDTH-1:0] MAG_MASK = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {COLLECT, WAIT_COST, WRITE} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [CW-1:0]         idx;
    logic [W-1:0]          buf_q [NUM_UNKOWNS];
    logic                  init_r;
    logic                  root_ready_q;
    logic [W-1:0]          mem_data_q;
    logic                  mem_wr_en_q;
    logic                  mem_update_weight_q;
    logic                  mem_initial_flag_q;
    logic [DATA_WIDTH-1:0] best_q;
    logic                  best_updated_q;
    logic                  seq_err_q;

    logic [CW-1:0]         sel_idx;
    logic                  sel_init;
    logic [CW-1:0]         sel_len;
    logic [W-1:0]          sel_word;
    logic [DATA_WIDTH-1:0] abs_cost;
    logic                  take;
    logic                  accept;
    logic                  emit;

    // The first word of a frame is emitted on the cost edge, so selection
    // follows first_iter there and init_r once the frame is running.
    always_comb begin
        sel_idx  = (state == WRITE) ? idx : '0;
        sel_init = (state == WRITE) ? init_r : bus.first_iter;
        sel_len  = sel_init ? FULL_LEN : ROOT_LEN;
        sel_word = PAD_VALUE;
        for (int i = 0; i < NUM_UNKOWNS; i++)
            if (sel_idx == CW'(i)) sel_word = buf_q[i];
        abs_cost = bus.cost_in & MAG_MASK;
        take     = bus.first_iter || (abs_cost < best_q);
        accept   = (state == COLLECT) && bus.root_valid && root_ready_q;
        emit     = ((state == WAIT_COST) && bus.cost_valid && take) ||
                   ((state == WRITE) && (idx != sel_len));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= COLLECT;
            count               <= '0;
            idx                 <= '0;
            init_r              <= 1'b0;
            root_ready_q        <= 1'b1;
            mem_data_q          <= '0;
            mem_wr_en_q         <= 1'b0;
            mem_update_weight_q <= 1'b0;
            mem_initial_flag_q  <= 1'b0;
            best_q              <= MAG_MASK;
            best_updated_q      <= 1'b0;
            seq_err_q           <= 1'b0;
            for (int i = 0; i < NUM_UNKOWNS; i++) buf_q[i] <= '0;
        end else begin
            mem_wr_en_q         <= 1'b0;
            mem_update_weight_q <= 1'b0;
            mem_initial_flag_q  <= 1'b0;
            best_updated_q      <= 1'b0;
            if (bus.cost_valid && (state != WAIT_COST)) seq_err_q <= 1'b1;
            if (emit) begin
                mem_wr_en_q         <= 1'b1;
                mem_data_q          <= sel_word;
                mem_update_weight_q <= !sel_init;
                mem_initial_flag_q  <= sel_init;
                best_updated_q      <= (sel_idx == sel_len - 1'b1);
            end
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_UNKOWNS; i++)
                            if (count == CW'(i)) buf_q[i] <= bus.root_in;
                        if (count == LAST_ROOT) begin
                            count        <= '0;
                            state        <= WAIT_COST;
                            root_ready_q <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                WAIT_COST: begin
                    if (bus.cost_valid) begin
                        if (take) begin
                            best_q <= abs_cost;
                            init_r <= bus.first_iter;
                            idx    <= CW'(1);
                            state  <= WRITE;
                        end else begin
                            state        <= COLLECT;
                            root_ready_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (idx == sel_len) begin
                        idx          <= '0;
                        state        <= COLLECT;
                        root_ready_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.root_ready        = root_ready_q;
    assign bus.mem_data          = mem_data_q;
    assign bus.mem_wr_en         = mem_wr_en_q;
    assign bus.mem_update_weight = mem_update_weight_q;
    assign bus.mem_initial_flag  = mem_initial_flag_q;
    assign bus.best_cost         = best_q;
    assign bus.best_updated      = best_updated_q;
    assign bus.seq_err           = seq_err_q;
endmodule
